// File: rtl/serial_magnitude_compare_ctrl.sv
// Sequencer that time-shares one external 4-bit cascadable magnitude comparator,
// walking the operands one nibble per clock, LSB nibble first, with the cascade fed back.
module serial_magnitude_compare_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic                   gt,
    output logic                   lt,
    output logic                   eq,
    output logic                   err,
    output logic [3:0]             cmp_a,
    output logic [3:0]             cmp_b,
    output logic                   cmp_igt,
    output logic                   cmp_ilt,
    output logic                   cmp_ieq,
    input  logic                   cmp_ogt,
    input  logic                   cmp_olt,
    input  logic                   cmp_oeq
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NIBBLES-1:0][3:0] a_q, a_d;
    logic [NIBBLES-1:0][3:0] b_q, b_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [2:0]              casc_q, casc_d;
    logic [2:0]              res_q, res_d;
    logic                    err_q, err_d;
    logic [2:0]              cmp_out;
    logic                    one_hot;

    assign cmp_out = {cmp_ogt, cmp_olt, cmp_oeq};

    always_comb begin
        one_hot = 1'b0;
        case (cmp_out)
            3'b100, 3'b010, 3'b001: one_hot = 1'b1;
            default:                one_hot = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        casc_d  = casc_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    casc_d  = 3'b001;
                    res_d   = 3'b000;
                    err_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                casc_d = cmp_out;
                err_d  = err_q | ~one_hot;
                // idx parks on the last nibble so cmp_a/cmp_b keep showing it afterwards
                if (idx_q == LAST_IDX) begin
                    res_d   = cmp_out;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            casc_q  <= 3'b001;
            res_q   <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign gt   = res_q[2];
    assign lt   = res_q[1];
    assign eq   = res_q[0];
    assign err  = err_q;

    assign cmp_a = a_q[idx_q];
    assign cmp_b = b_q[idx_q];
    assign {cmp_igt, cmp_ilt, cmp_ieq} = busy ? casc_q : 3'b001;

endmodule
